eight_way_serial_demux: RTL and testbench



---
 rtl/eight_way_serial_demux.sv | 93 +++++++++
 tb/tb_eight_way_serial_demux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/eight_way_serial_demux.sv
// Serial-to-parallel demux: routes each accepted bit into one of eight frame
// positions and presents the completed frame with a valid/ready handshake.
module eight_way_serial_demux #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    input  logic flush,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out5,
    output logic out6,
    output logic out7,
    output logic out_valid,
    input  logic out_ready,
    output logic s0,
    output logic s1,
    output logic s2
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [2:0]  index, index_n;
    logic [7:0]  capture, capture_n;
    logic [7:0]  frame, frame_n;
    logic [2:0]  pos;

    assign pos = MSB_FIRST ? (3'd7 - index) : index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            index   <= 3'd0;
            capture <= 8'd0;
            frame   <= 8'd0;
        end else begin
            state   <= state_n;
            index   <= index_n;
            capture <= capture_n;
            frame   <= frame_n;
        end
    end

    // In FILL every in_valid is a transfer because in_ready is high there.
    always_comb begin
        state_n   = state;
        index_n   = index;
        capture_n = capture;
        frame_n   = frame;
        case (state)
            FILL: begin
                if (flush) begin
                    index_n   = 3'd0;
                    capture_n = 8'd0;
                end else if (in_valid) begin
                    capture_n[pos] = in_bit;
                    if (index == 3'd7) begin
                        frame_n   = capture_n;
                        capture_n = 8'd0;
                        index_n   = 3'd0;
                        state_n   = FULL;
                    end else begin
                        index_n = index + 3'd1;
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_n = FILL;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign {out7, out6, out5, out4, out3, out2, out1, out0} = frame;
    assign {s2, s1, s0} = index;

endmodule

// File: tb/tb_eight_way_serial_demux.sv
// Directed bench for eight_way_serial_demux; one instance per bit order,
// both driven by the same stimulus.
module tb_eight_way_serial_demux;

    typedef struct {
        string      name;
        logic [7:0] seq;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    logic clk;
    logic rst;
    logic in_bit;
    logic in_valid;
    logic flush;
    logic out_ready;

    logic a_in_ready, a_out_valid, a_s0, a_s1, a_s2;
    logic a_o0, a_o1, a_o2, a_o3, a_o4, a_o5, a_o6, a_o7;
    logic b_in_ready, b_out_valid, b_s0, b_s1, b_s2;
    logic b_o0, b_o1, b_o2, b_o3, b_o4, b_o5, b_o6, b_o7;

    logic [7:0] frame0, frame1;
    logic [2:0] idx0, idx1;
    logic [7:0] prev0, prev1;

    int testsRun;
    int failCount;
    vec_t vecs[10];

    eight_way_serial_demux #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(a_in_ready), .flush(flush),
        .out0(a_o0), .out1(a_o1), .out2(a_o2), .out3(a_o3),
        .out4(a_o4), .out5(a_o5), .out6(a_o6), .out7(a_o7),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .s0(a_s0), .s1(a_s1), .s2(a_s2)
    );

    eight_way_serial_demux #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(b_in_ready), .flush(flush),
        .out0(b_o0), .out1(b_o1), .out2(b_o2), .out3(b_o3),
        .out4(b_o4), .out5(b_o5), .out6(b_o6), .out7(b_o7),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .s0(b_s0), .s1(b_s1), .s2(b_s2)
    );

    assign frame0 = {a_o7, a_o6, a_o5, a_o4, a_o3, a_o2, a_o1, a_o0};
    assign frame1 = {b_o7, b_o6, b_o5, b_o4, b_o3, b_o2, b_o1, b_o0};
    assign idx0   = {a_s2, a_s1, a_s0};
    assign idx1   = {b_s2, b_s1, b_s0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkHandshake(input string tag, input logic valid_exp);
        checkOutput({tag, " out_valid0"}, {7'd0, a_out_valid}, {7'd0, valid_exp});
        checkOutput({tag, " in_ready0"},  {7'd0, a_in_ready},  {7'd0, ~valid_exp});
        checkOutput({tag, " out_valid1"}, {7'd0, b_out_valid}, {7'd0, valid_exp});
        checkOutput({tag, " in_ready1"},  {7'd0, b_in_ready},  {7'd0, ~valid_exp});
    endtask

    task automatic checkIndex(input string tag, input logic [2:0] expected);
        checkOutput({tag, " index0"}, {5'd0, idx0}, {5'd0, expected});
        checkOutput({tag, " index1"}, {5'd0, idx1}, {5'd0, expected});
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, " frame0 held"}, frame0, prev0);
        checkOutput({tag, " frame1 held"}, frame1, prev1);
    endtask

    task automatic releaseFrame(input string tag);
        out_ready = 1'b1;
        stepClock();
        out_ready = 1'b0;
        checkHandshake({tag, " release"}, 1'b0);
        checkHeld({tag, " release"});
        checkIndex({tag, " release"}, 3'd0);
    endtask

    // Feeds one full frame back-to-back, first bit taken from seq[7].
    task automatic applyStimulus(input vec_t v, input bit doRelease);
        for (int i = 0; i < 8; i++) begin
            in_bit   = v.seq[7 - i];
            in_valid = 1'b1;
            stepClock();
            if (i < 7) begin
                checkIndex(v.name, 3'(i + 1));
                checkHandshake(v.name, 1'b0);
                checkHeld(v.name);
            end
        end
        in_valid = 1'b0;
        checkIndex({v.name, " done"}, 3'd0);
        checkHandshake({v.name, " done"}, 1'b1);
        checkOutput({v.name, " frame0"}, frame0, v.exp0);
        checkOutput({v.name, " frame1"}, frame1, v.exp1);
        prev0 = v.exp0;
        prev1 = v.exp1;
        if (doRelease) begin
            releaseFrame(v.name);
        end
    endtask

    task automatic sendPartial(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            in_bit   = 1'b1;
            in_valid = 1'b1;
            stepClock();
            checkIndex(tag, 3'(i + 1));
            checkHeld(tag);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        rst       = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        prev0     = 8'h00;
        prev1     = 8'h00;

        vecs[0] = '{"basic",   8'b1011_0010, 8'b0100_1101, 8'b1011_0010};
        vecs[1] = '{"onehot0", 8'b1000_0000, 8'b0000_0001, 8'b1000_0000};
        vecs[2] = '{"onehot1", 8'b0100_0000, 8'b0000_0010, 8'b0100_0000};
        vecs[3] = '{"onehot2", 8'b0010_0000, 8'b0000_0100, 8'b0010_0000};
        vecs[4] = '{"onehot3", 8'b0001_0000, 8'b0000_1000, 8'b0001_0000};
        vecs[5] = '{"onehot4", 8'b0000_1000, 8'b0001_0000, 8'b0000_1000};
        vecs[6] = '{"onehot5", 8'b0000_0100, 8'b0010_0000, 8'b0000_0100};
        vecs[7] = '{"onehot6", 8'b0000_0010, 8'b0100_0000, 8'b0000_0010};
        vecs[8] = '{"onehot7", 8'b0000_0001, 8'b1000_0000, 8'b0000_0001};
        vecs[9] = '{"clean",   8'b0110_1001, 8'b1001_0110, 8'b0110_1001};

        // Reset held for two cycles.
        stepClock();
        stepClock();
        rst = 1'b0;
        checkHandshake("reset", 1'b0);
        checkIndex("reset", 3'd0);
        checkHeld("reset");

        // Basic frame, then backpressure with in_valid and flush while FULL.
        applyStimulus(vecs[0], 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bit   = c[0];
            flush    = (c == 2);
            stepClock();
            checkHandshake("backpressure", 1'b1);
            checkIndex("backpressure", 3'd0);
            checkHeld("backpressure");
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        releaseFrame("backpressure");

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(vecs[k], 1'b1);
        end

        // Flush together with in_valid drops that bit and clears the index.
        sendPartial("preflush", 3);
        in_bit   = 1'b1;
        in_valid = 1'b1;
        flush    = 1'b1;
        stepClock();
        in_valid = 1'b0;
        flush    = 1'b0;
        checkIndex("flush", 3'd0);
        checkHandshake("flush", 1'b0);
        checkHeld("flush");
        applyStimulus(vecs[9], 1'b1);

        // Mid-frame reset clears partial bits and the held frame.
        sendPartial("prereset", 5);
        rst = 1'b1;
        stepClock();
        rst   = 1'b0;
        prev0 = 8'h00;
        prev1 = 8'h00;
        checkIndex("midreset", 3'd0);
        checkHandshake("midreset", 1'b0);
        checkHeld("midreset");
        applyStimulus(vecs[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
